// File: rtl/sram_like_slave_mem.sv
// ---------------------------------------------------------------------------
// sram_like_slave_mem
//
// Responder end of the SRAM-like request/response bus used by the CPU fetch
// and load/store ports. A word-organised memory sits behind an in-order queue
// of accepted-but-unanswered requests. Every response waits at least LAT
// cycles after its address handshake. Two stall inputs can hold back the
// address side and the data side. One instance serves the instruction port and
// another serves the data port in the simulation and FPGA test tops.
//
// Parameters
//   MEM_AW  word-address width; the memory holds 2**MEM_AW 32-bit words
//   DEPTH   max outstanding requests (power of 2, >= 2)
//   LAT     min cycles from address handshake to data_ok (>= 1)
//
// Ports
//   clk          clock, rising edge
//   resetn       asynchronous active-low reset
//   req          master request valid
//   wr           1 = write, 0 = read
//   size         access size; informational, a full word is always read
//   wstrb        byte write enables for writes
//   addr         byte address; word index = addr[MEM_AW+1:2]
//   wdata        write data, byte lanes selected by wstrb
//   addr_ok      request accepted this cycle when req & addr_ok
//   data_ok      one-cycle response pulse per accepted request, in order
//   rdata        read word, valid only in the data_ok cycle of a read
//   addr_stall   stall input: forces addr_ok low
//   data_stall   stall input: holds back data_ok while high
//   outstanding  current queue occupancy
// ---------------------------------------------------------------------------
module sram_like_slave_mem #(
    parameter int MEM_AW = 14,
    parameter int DEPTH  = 4,
    parameter int LAT    = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req,
    input  logic                   wr,
    input  logic [1:0]             size,
    input  logic [3:0]             wstrb,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   addr_ok,
    output logic                   data_ok,
    output logic [31:0]            rdata,
    input  logic                   addr_stall,
    input  logic                   data_stall,
    output logic [$clog2(DEPTH):0] outstanding
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_INIT = TW'(LAT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    // With LAT = 1 a request that finds nothing ahead of it must answer on the
    // very next cycle. A queued entry cannot do that, so it bypasses the queue.
    localparam logic          BYPASS_EN  = (LAT == 1);

    // ------------------------------------------------------------------
    // Storage: backing memory and the queue payload
    // ------------------------------------------------------------------
    logic [31:0]   mem_q       [2**MEM_AW];
    logic          ent_wr_q    [DEPTH];
    logic [31:0]   ent_rdata_q [DEPTH];
    logic [TW-1:0] ent_timer_q [DEPTH];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [PW-1:0] head_q,    head_d;
    logic [PW-1:0] tail_q,    tail_d;
    logic [CW-1:0] count_q,   count_d;
    logic          data_ok_q, data_ok_d;
    logic [31:0]   rdata_q,   rdata_d;

    logic [MEM_AW-1:0] word_idx;
    logic [CW-1:0]     live;
    logic              hs;
    logic              head_ready;
    logic              pop;
    logic              bypass;
    logic              push;

    // size and the address bits outside the word index carry no information
    // for a word-organised memory.
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    assign word_idx = addr[MEM_AW+1:2];

    // Occupancy counts an entry until the end of its data_ok cycle. A response
    // going out this cycle therefore does not free a slot for this cycle.
    assign addr_ok = resetn & ~addr_stall & (count_q < DEPTH_C);
    assign hs      = req & addr_ok;

    // Entries still waiting for a response. The entry whose data_ok is showing
    // right now has already left the slot array but still counts as occupied.
    assign live = count_q - CW'(data_ok_q);

    // data_ok is registered. The head is therefore chosen one cycle early:
    // when its timer reads 1 now, it reaches 0 at the same edge that raises
    // data_ok. This gives the earliest response at handshake cycle + LAT.
    assign head_ready = (live != '0) && (ent_timer_q[head_q] <= TIMER_ONE);
    assign pop        = head_ready & ~data_stall;
    assign bypass     = BYPASS_EN & hs & (live == '0) & ~data_stall;
    assign push       = hs & ~bypass;

    // NOTE: every signal written here gets a default first. A path that leaves
    // a signal unassigned would infer a latch.
    always_comb begin
        count_d   = count_q + CW'(hs) - CW'(data_ok_q);
        head_d    = head_q + PW'(pop);
        tail_d    = tail_q + PW'(push);
        data_ok_d = pop | bypass;
        rdata_d   = '0;
        if (pop) begin
            if (!ent_wr_q[head_q]) begin
                rdata_d = ent_rdata_q[head_q];
            end
        end else if (bypass && !wr) begin
            rdata_d = mem_q[word_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
        end
    end

    // NOTE: the memory and the queue payload have no reset. Memory contents
    // must survive reset. Payload slots only matter between a push and the
    // matching pop, and the reset counters already mark them empty.
    always_ff @(posedge clk) begin
        // Timers run for every slot. Only live slots are ever consulted, and a
        // push reloads its slot below.
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_timer_q[i] != '0) begin
                ent_timer_q[i] <= ent_timer_q[i] - TIMER_ONE;
            end
        end

        if (push) begin
            ent_wr_q[tail_q]    <= wr;
            // A read samples the word at the handshake edge. It therefore sees
            // every write accepted on an earlier cycle.
            ent_rdata_q[tail_q] <= mem_q[word_idx];
            ent_timer_q[tail_q] <= TIMER_INIT;
        end

        if (hs && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_ok     = data_ok_q;
    assign rdata       = rdata_q;
    assign outstanding = count_q;

endmodule

// File: tb/tb_sram_like_slave_mem.sv
module tb_sram_like_slave_mem;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int LAT4  = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_stall;
    logic        data_stall;

    logic        addr_ok,  data_ok,  addr_ok4, data_ok4;
    logic [31:0] rdata,    rdata4;
    logic [2:0]  outstanding, outstanding4;

    always #5 clk = ~clk;

    sram_like_slave_mem #(.MEM_AW(14), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .addr_stall(addr_stall), .data_stall(data_stall), .outstanding(outstanding)
    );

    sram_like_slave_mem #(.MEM_AW(14), .DEPTH(DEPTH), .LAT(LAT4)) dut4 (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok4), .data_ok(data_ok4), .rdata(rdata4),
        .addr_stall(addr_stall), .data_stall(data_stall), .outstanding(outstanding4)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model for the LAT = 2 instance. It holds unanswered requests
    // with their acceptance cycle, plus a plain word array for the memory.
    typedef struct {
        int          acc;
        bit          is_wr;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mref [0:16383];
    bit          exp_dok = 1'b0;
    logic [31:0] exp_rd  = '0;

    // Output samples from the most recent cycle, taken at the falling edge.
    logic        s_aok, s_dok, s_aok4, s_dok4;
    logic [31:0] s_rd, s_rd4;
    logic [2:0]  s_out, s_out4;

    logic [31:0] val4 [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dok = 1'b0;
        exp_rd  = '0;
    endtask

    // One bus cycle. Outputs are checked at the falling edge against the model.
    // The model then advances using this cycle's inputs, and the task returns
    // 1 ns after the next rising edge so the caller can drive the next cycle.
    task automatic tick();
        ent_t        e;
        int          w;
        int          occ;
        bit          eaok;
        logic [31:0] tmp;
        @(negedge clk);
        s_aok  = addr_ok;  s_dok  = data_ok;  s_rd  = rdata;  s_out  = outstanding;
        s_aok4 = addr_ok4; s_dok4 = data_ok4; s_rd4 = rdata4; s_out4 = outstanding4;
        occ  = q.size() + (exp_dok ? 1 : 0);
        eaok = resetn && !addr_stall && (occ < DEPTH);
        chk("addr_ok", {31'd0, addr_ok}, {31'd0, eaok});
        chk("outstanding", {29'd0, outstanding}, occ);
        chk("data_ok", {31'd0, data_ok}, {31'd0, exp_dok});
        if (exp_dok) chk("rdata", rdata, exp_rd);
        if (!resetn) begin
            model_reset();
        end else begin
            w = int'(addr[15:2]);
            if (req && eaok) begin
                e.acc   = cyc;
                e.is_wr = wr;
                e.d     = wr ? 32'h0 : mref[w];
                if (wr) begin
                    tmp = mref[w];
                    for (int b = 0; b < 4; b++) if (wstrb[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
                    mref[w] = tmp;
                end
                q.push_back(e);
            end
            exp_dok = 1'b0;
            exp_rd  = '0;
            if (q.size() > 0 && !data_stall && (cyc + 1 >= q[0].acc + LAT)) begin
                exp_dok = 1'b1;
                exp_rd  = q[0].d;
                q.delete(0);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) tick();
    endtask

    // Full-word write, then enough idle cycles for both instances to drain.
    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = a; wdata = d;
        tick();
        req = 1'b0; wr = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int n;
        bit e4;

        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = '0;
        addr = '0; wdata = '0; addr_stall = 1'b0; data_stall = 1'b0;
        for (int i = 0; i < 5; i++) val4[i] = 32'hC0DE_0000 | (32'h1111 * (i + 1));

        // Reset state.
        repeat (2) tick();
        chk("rst_rdata", s_rd, 32'h0);
        chk("rst_aok4", {31'd0, s_aok4}, 32'd0);
        chk("rst_out4", {29'd0, s_out4}, 32'd0);
        chk("rst_dok4", {31'd0, s_dok4}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("aok_after_release", {31'd0, s_aok}, 32'd1);

        // Preload memory through the bus.
        wr_word(32'h10, 32'h1122_3344);
        for (int i = 0; i < 5; i++) wr_word(32'h100 + 32'(4 * i), val4[i]);
        for (int i = 0; i < 8; i++) wr_word(32'h200 + 32'(4 * i), $urandom);

        // Reset with memory preloaded: the queue empties and the memory keeps its contents.
        resetn = 1'b0; model_reset();
        tick();
        chk("rst2_aok", {31'd0, s_aok}, 32'd0);
        chk("rst2_out", {29'd0, s_out}, 32'd0);
        resetn = 1'b1;
        tick();

        // Partial write, then read back (LAT = 2).
        req = 1'b1; wr = 1'b1; addr = 32'h10; wstrb = 4'b0011; wdata = 32'hAABB_CCDD;
        tick();
        wr = 1'b0;
        tick();
        req = 1'b0;
        tick();
        chk("wr_dok_t2", {31'd0, s_dok}, 32'd1);
        chk("wr_rdata_zero", s_rd, 32'h0);
        tick();
        chk("rd_dok_t3", {31'd0, s_dok}, 32'd1);
        chk("rd_rdata_merge", s_rd, 32'h1122_CCDD);
        idle(3);

        // LAT = 4 instance: five back-to-back reads with a depth of four.
        n = 0;
        for (int k = 0; k < 10; k++) begin
            req = (n < 5); wr = 1'b0; addr = 32'h100 + 32'(4 * n);
            tick();
            if (k <= 5) chk($sformatf("lat4_aok_k%0d", k), {31'd0, s_aok4}, (k != 4) ? 32'd1 : 32'd0);
            if (k < 4 || k == 5) n++;
            e4 = (k >= 4 && k <= 7) || k == 9;
            chk($sformatf("lat4_dok_k%0d", k), {31'd0, s_dok4}, e4 ? 32'd1 : 32'd0);
            if (e4) chk($sformatf("lat4_rdata_k%0d", k), s_rd4, val4[(k == 9) ? 4 : k - 4]);
        end
        idle(4);

        // data_stall with three reads queued.
        data_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 1'b1; wr = 1'b0; addr = 32'h200 + 32'(4 * i);
            tick();
        end
        req = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("stall_no_dok", {31'd0, s_dok}, 32'd0);
        end
        chk("stall_out3", {29'd0, s_out}, 32'd3);
        data_stall = 1'b0;
        tick();
        chk("stall_release_cycle", {31'd0, s_dok}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_burst_dok", {31'd0, s_dok}, 32'd1);
            chk("stall_burst_rdata", s_rd, mref[128 + i]);
        end
        idle(2);

        // addr_stall while a request is pending.
        addr_stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h204;
        repeat (3) begin
            tick();
            chk("astall_aok", {31'd0, s_aok}, 32'd0);
            chk("astall_out", {29'd0, s_out}, 32'd0);
        end
        addr_stall = 1'b0;
        tick();
        chk("astall_release_aok", {31'd0, s_aok}, 32'd1);
        req = 1'b0;
        tick();
        chk("astall_out1", {29'd0, s_out}, 32'd1);
        tick();
        chk("astall_dok", {31'd0, s_dok}, 32'd1);
        chk("astall_rdata", s_rd, mref[129]);
        idle(2);

        // Reset with two entries outstanding.
        req = 1'b1; wr = 1'b0; addr = 32'h208;
        tick();
        addr = 32'h20C;
        tick();
        req = 1'b0;
        resetn = 1'b0; model_reset();
        tick();
        chk("midrst_dok", {31'd0, s_dok}, 32'd0);
        chk("midrst_out", {29'd0, s_out}, 32'd0);
        resetn = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("midrst_no_stale", {31'd0, s_dok}, 32'd0);
        end

        // Randomised traffic against the model. Address bits outside the word
        // index are randomised as well.
        for (int j = 0; j < 400; j++) begin
            req        = ($urandom_range(0, 1) == 1);
            wr         = ($urandom_range(0, 2) == 0);
            wstrb      = 4'($urandom_range(0, 15));
            addr       = ($urandom & 32'hFFFF_0000) | (32'h200 + 32'(4 * $urandom_range(0, 7)))
                         | 32'($urandom_range(0, 3));
            wdata      = $urandom;
            addr_stall = ($urandom_range(0, 6) == 0);
            data_stall = ($urandom_range(0, 4) == 0);
            tick();
        end
        addr_stall = 1'b0; data_stall = 1'b0;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
